// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter: widths, abort data, FSM states.
package arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Returned to the requester when an access is aborted by the watchdog.
    localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-cycle watchdog: counts BUSY cycles without ack and flags expiry at TIMEOUT.
// TIMEOUT = 0 disables expiry entirely.
module mem_arb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Wait counter: cleared between accesses, advances on each unacknowledged cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // Expiry flag, valid in the same cycle the count reaches TIMEOUT.
    always_comb begin
        expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one shared memory port.
// Data wins contention unless the fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [STRB_W-1:0] dm_wstrb,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              bus_err
);

    localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          grant_i;
    logic          grant_d;
    logic          done;
    logic          abort;
    logic          wd_clear;
    logic          wd_en;
    logic          wd_expired;

    assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration decision, completion/abort detection and requester handshakes.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        wd_clear  = 1'b0;
        wd_en     = 1'b0;
        if_ready  = 1'b0;
        dm_ready  = 1'b0;
        bus_err   = 1'b0;
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        case (state)
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (dm_req && !(if_req && starve_full)) begin
                    grant_d   = 1'b1;
                    state_nxt = ST_BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                wd_en   = !mem_ack;
                // An ack arriving in the expiry cycle still completes normally.
                abort   = wd_expired && !mem_ack;
                done    = mem_ack || wd_expired;
                bus_err = abort;
                if (done) begin
                    state_nxt = ST_IDLE;
                end
                if (state == ST_BUSY_I) begin
                    if_ready = done;
                    if (abort) begin
                        if_rdata = ABORT_DATA;
                    end
                end else begin
                    dm_ready = done;
                    if (abort) begin
                        dm_rdata = ABORT_DATA;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        stall_if = if_req & ~if_ready;
        stall_dm = dm_req & ~dm_ready;
    end

    // Memory port register: loaded from the winner on grant, held through BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Starvation counter: consecutive data wins over a waiting fetch, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && !starve_full) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model schedules grants
// and completions; a monitor checks the DUT against the queued expectations.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE = 4;
    localparam int unsigned TO     = 8;
    localparam int          STARVE_I = 4;
    localparam int          TO_I     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_dm;
    logic        bus_err;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE),
        .TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          port;      // 0 = fetch, 1 = data
        logic [31:0] data;
        bit          err;
    } cmp_t;

    typedef struct {
        int          rise;
        int          fall;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
    } gnt_t;

    typedef enum int { M_NONE, M_RAND, M_STARVE } mode_t;

    cmp_t  cq[$];
    gnt_t  gq[$];
    int    nvec = 0;
    int    nerr = 0;
    int    cyc  = 0;
    bit    mon_en = 0;
    mode_t mode = M_NONE;

    // requester state
    bit          i_act = 0;
    logic [31:0] i_addr = '0;
    bit          d_act = 0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;

    // arbiter model state
    bit          m_busy = 0;
    bit          m_win = 0;
    bit          m_kill = 0;
    int          t0 = 0;
    int          m_end = 0;
    int          starve = 0;
    int          ack_cyc = -1;
    logic [31:0] ack_data = '0;

    // one-shot forced response plan
    bit          fp_valid = 0;
    bit          fp_ack = 0;
    bit          fp_kill = 0;
    int          fp_L = 0;
    logic [31:0] fp_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic new_fetch();
        i_act  = 1;
        i_addr = $urandom;
    endtask

    task automatic new_data();
        d_act   = 1;
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom);
    endtask

    task automatic decide();
        bit          win_d;
        bit          ackd;
        bit          kill;
        int          lat;
        int          r;
        logic [31:0] data;
        gnt_t        g;
        cmp_t        c;
        win_d = d_act && !(i_act && starve == STARVE_I);
        if (win_d) begin
            if (i_act && starve < STARVE_I) starve++;
        end else begin
            starve = 0;
        end
        if (fp_valid) begin
            lat = fp_L; ackd = fp_ack; kill = fp_kill; data = fp_data;
            fp_valid = 0;
        end else begin
            kill = 0;
            data = $urandom;
            r = int'($urandom_range(9, 0));
            if (r <= 6)      begin lat = int'($urandom_range(3, 0)); ackd = 1; end
            else if (r == 7) begin lat = TO_I;     ackd = 0; end
            else if (r == 8) begin lat = TO_I;     ackd = 1; end
            else             begin lat = TO_I - 1; ackd = 1; end
        end
        t0     = cyc;
        m_busy = 1;
        m_win  = win_d;
        m_kill = kill;
        m_end  = kill ? cyc + 1000 : cyc + 1 + lat;
        g.rise = cyc + 1;
        g.fall = kill ? cyc + 3 : m_end + 1;
        if (win_d) begin
            g.we = d_we; g.addr = d_addr; g.wdata = d_wdata; g.wstrb = d_wstrb; g.chk_wdata = 1;
        end else begin
            g.we = 1'b0; g.addr = i_addr; g.wdata = '0; g.wstrb = 4'h0; g.chk_wdata = 0;
        end
        gq.push_back(g);
        ack_cyc  = (ackd && !kill) ? m_end : -1;
        ack_data = data;
        if (!kill) begin
            c.cyc  = m_end;
            c.port = win_d;
            c.data = ackd ? data : 32'hDEAD_BEEF;
            c.err  = !ackd;
            cq.push_back(c);
        end
    endtask

    task automatic drive();
        bit busy_now;
        busy_now  = m_busy && (cyc > t0) && (cyc <= m_end);
        if_req    = i_act;
        if_addr   = i_addr;
        dm_req    = d_act;
        dm_we     = d_we;
        dm_addr   = d_addr;
        dm_wdata  = d_wdata;
        dm_wstrb  = d_wstrb;
        // stray acks are only offered while the arbiter should be idle
        mem_ack   = (cyc == ack_cyc) || (!busy_now && ($urandom_range(3, 0) == 0));
        mem_rdata = (cyc == ack_cyc) ? ack_data : $urandom;
    endtask

    task automatic step();
        if (m_busy && !m_kill && cyc == m_end + 1) begin
            m_busy = 0;
            if (m_win) d_act = 0;
            else       i_act = 0;
        end
        case (mode)
            M_RAND: begin
                if (!i_act && $urandom_range(1, 0) == 1) new_fetch();
                if (!d_act && $urandom_range(1, 0) == 1) new_data();
            end
            M_STARVE: begin
                if (!i_act) new_fetch();
                if (!d_act) new_data();
            end
            default: ;
        endcase
        if (!m_busy && (i_act || d_act)) decide();
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && (m_busy || i_act || d_act); k++) tick();
        chk("drain_timeout", {31'd0, (m_busy || i_act || d_act)}, 32'd0);
        tick();
        tick();
    endtask

    // Monitor: checks handshakes every cycle and pops expectations when the DUT responds.
    initial begin : monitor
        gnt_t cur;
        cmp_t e;
        bit   have_cur = 0;
        bit   prev_req = 0;
        bit   exp_i;
        bit   exp_d;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                chk("missed_ready", 32'd0, 32'd1);
                void'(cq.pop_front());
            end
            exp_i = (cq.size() > 0) && (cq[0].cyc == cyc) && !cq[0].port;
            exp_d = (cq.size() > 0) && (cq[0].cyc == cyc) &&  cq[0].port;
            chk("if_ready", {31'd0, if_ready}, {31'd0, exp_i});
            chk("dm_ready", {31'd0, dm_ready}, {31'd0, exp_d});
            chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~exp_i});
            chk("stall_dm", {31'd0, stall_dm}, {31'd0, dm_req & ~exp_d});
            if (exp_i || exp_d) begin
                e = cq.pop_front();
                if (e.port) chk("dm_rdata", dm_rdata, e.data);
                else        chk("if_rdata", if_rdata, e.data);
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end else begin
                chk("bus_err_idle", {31'd0, bus_err}, 32'd0);
            end
            while (gq.size() > 0 && gq[0].rise < cyc) begin
                chk("missed_grant", 32'd0, 32'd1);
                void'(gq.pop_front());
            end
            if (mem_req && !prev_req) begin
                if (gq.size() > 0 && gq[0].rise == cyc) begin
                    cur = gq.pop_front();
                    have_cur = 1;
                end else begin
                    chk("unexpected_grant", 32'd1, 32'd0);
                    have_cur = 0;
                end
            end
            if (mem_req && have_cur) begin
                chk("mem_we",   {31'd0, mem_we}, {31'd0, cur.we});
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
                if (cur.chk_wdata) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (!mem_req && prev_req && have_cur) begin
                chk("mem_req_fall", 32'(cyc), 32'(cur.fall));
                have_cur = 0;
            end
            prev_req = mem_req;
        end
    end

    // Stimulus: directed scenarios, a random phase, then mid-access reset.
    initial begin : stim
        reset = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_if_ready",  {31'd0, if_ready}, 32'd0);
        chk("rst_dm_ready",  {31'd0, dm_ready}, 32'd0);
        chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
        #1;
        reset  = 1'b1;
        mon_en = 1;

        // single fetch, decided on the first edge out of reset
        i_act = 1; i_addr = 32'h0000_0100;
        fp_valid = 1; fp_L = 2; fp_ack = 1; fp_kill = 0; fp_data = 32'h0050_0093;
        step();
        drain();

        // contention: store and fetch requested together
        d_act = 1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h0000_1234; d_wstrb = 4'hF;
        i_act = 1; i_addr = 32'h0000_0104;
        fp_valid = 1; fp_L = 1; fp_ack = 1; fp_kill = 0; fp_data = 32'h1111_2222;
        tick();
        drain();

        // load with no ack: abort after TIMEOUT cycles
        d_act = 1; d_we = 1'b0; d_addr = 32'h0000_0040; d_wdata = '0; d_wstrb = 4'h0;
        fp_valid = 1; fp_L = TO_I; fp_ack = 0; fp_kill = 0; fp_data = 32'h0;
        tick();
        drain();

        // ack in the very cycle the watchdog expires
        d_act = 1; d_we = 1'b0; d_addr = 32'h0000_0044;
        fp_valid = 1; fp_L = TO_I; fp_ack = 1; fp_kill = 0; fp_data = 32'hCAFE_0001;
        tick();
        drain();

        // fetch held while data re-requests continuously
        fp_valid = 0;
        mode = M_STARVE;
        repeat (60) tick();
        mode = M_NONE;
        drain();

        mode = M_RAND;
        repeat (600) tick();
        mode = M_NONE;
        drain();

        // reset in the third BUSY_D cycle abandons the access
        d_act = 1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wstrb = 4'h0;
        fp_valid = 1; fp_L = 0; fp_ack = 0; fp_kill = 1; fp_data = 32'h0;
        tick();
        repeat (3) tick();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mid_dm_ready", {31'd0, dm_ready}, 32'd0);
        chk("rst_mid_bus_err",  {31'd0, bus_err}, 32'd0);
        m_busy = 0; m_kill = 0; starve = 0; d_act = 0; i_act = 0; ack_cyc = -1;
        drive();
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();

        i_act = 1; i_addr = 32'h0000_0100;
        fp_valid = 1; fp_L = 2; fp_ack = 1; fp_kill = 0; fp_data = 32'h0050_0093;
        tick();
        drain();

        repeat (3) tick();
        chk("leftover_completions", 32'(cq.size()), 32'd0);
        chk("leftover_grants",      32'(gq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIMIT, default 4, max consecutive data wins over a pending fetch.
REQ-002 SHALL take parameter TIMEOUT, default 255, cycles waiting for mem_ack before abort (0 = disabled).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1; if_addr  in  32: fetch request and word address.
REQ-007 if_rdata  out  32; if_ready  out  1: fetch data and one-cycle completion.
REQ-008 dm_req  in  1; dm_we  in  1; dm_addr  in  32; dm_wdata  in  32; dm_wstrb  in  4: data access request.
REQ-009 dm_rdata  out  32; dm_ready  out  1: load data and one-cycle completion.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_wstrb  out  4: shared memory port.
REQ-011 mem_rdata  in  32; mem_ack  in  1: memory response, valid when mem_ack=1.
REQ-012 stall_if  out  1; stall_dm  out  1: requester held this cycle.
REQ-013 bus_err  out  1: one-cycle pulse on timeout abort.

Function
REQ-014 SHALL implement FSM IDLE, BUSY_I, BUSY_D.
REQ-015 IDLE: dm_req only -> BUSY_D; if_req only -> BUSY_I; both -> BUSY_D unless starve count = STARVE_LIMIT, then BUSY_I; neither -> IDLE.
REQ-016 On entering BUSY_x, mem_req and all mem_* fields SHALL be registered from the winner's inputs; mem_req rises one cycle after the IDLE decision cycle.
REQ-017 mem_* SHALL hold stable throughout BUSY_x; mem_we=0, mem_wstrb=0 in BUSY_I.
REQ-018 In BUSY_x with mem_ack=1: x_ready=1 and x_rdata=mem_rdata that cycle (combinational); next state IDLE; mem_req low next cycle.
REQ-019 Minimum access latency: 2 cycles from req to ready (decision cycle + ack cycle); one IDLE cycle between consecutive grants.
REQ-020 Requesters SHALL hold req and fields stable until ready; req high in cycle after ready is a new transaction.
REQ-021 Starve counter (3 bits min): +1 when BUSY_D granted while if_req=1; cleared on BUSY_I grant; saturates at STARVE_LIMIT.
REQ-022 Wait counter: cleared on BUSY entry, +1 per BUSY cycle without ack; reaching TIMEOUT -> x_ready=1, x_rdata=32'hDEAD_BEEF, bus_err=1 for one cycle, next state IDLE.
REQ-023 mem_ack and timeout in the same cycle: ack wins, no bus_err.
REQ-024 mem_ack in IDLE SHALL be ignored.
REQ-025 stall_if = if_req & ~if_ready; stall_dm = dm_req & ~dm_ready.
REQ-026 dm_rdata for stores SHALL equal mem_rdata (don't-care to requester).

Reset
REQ-027 reset=0 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, counters=0, bus_err=0, both ready=0.
REQ-028 Reset mid-transaction SHALL abandon it silently: no ready, no bus_err after release.
REQ-029 First arbitration SHALL occur on the first rising edge with reset=1.

Structure
REQ-030 Shared package arb_pkg: state enumeration, ABORT_DATA=32'hDEAD_BEEF, address/data/strobe widths.
REQ-031 Wait/timeout counter SHALL be sub-module mem_arb_wdog (clear, enable, expired); remaining logic inline.

Verification
REQ-032 Single fetch: if_req=1, if_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, if_ready one cycle, if_rdata=0x00500093.
REQ-033 Contention: if_req and dm_req (sw, addr 0x2000, wdata 0x1234, wstrb 0xF) same cycle -> data granted first with mem_we=1, then fetch; stall_if high until if_ready.
REQ-034 Starvation: if_req held, dm_req re-issued every cycle after ready -> 4 data grants, 5th grant is BUSY_I.
REQ-035 Timeout with TIMEOUT=8, no ack -> 8 cycles after mem_req rises: dm_ready=1, dm_rdata=0xDEADBEEF, bus_err=1 one cycle; mem_ack at cycle 8 exactly -> normal completion, bus_err=0.
REQ-036 Reset in BUSY_D cycle 3 -> mem_req=0 immediately; after release no ready pulse; fresh if_req served normally.
